// File: rtl/motordc_pwm_dir_drv_if.sv
// Register-bank to power-stage bundle for the DC-motor PWM/direction driver.
// The master side (register bank) drives the settings; the slave side
// (motordc_pwm_dir_drv) returns the bridge drive and status.
interface motordc_pwm_dir_drv_if #(
    parameter int unsigned CNT_W = 16
);
    logic             en;
    logic             dir;
    logic [CNT_W-1:0] duty;
    logic [CNT_W-1:0] period;
    logic             in1;
    logic             in2;
    logic             dir_act;
    logic [1:0]       state_o;
    logic             period_tick;

    modport master (
        output en, dir, duty, period,
        input  in1, in2, dir_act, state_o, period_tick
    );

    modport slave (
        input  en, dir, duty, period,
        output in1, in2, dir_act, state_o, period_tick
    );
endinterface

// File: rtl/motordc_pwm_dir_drv.sv
// H-bridge driver: edge-aligned PWM on IN1 (forward) or IN2 (reverse) with a
// fixed dead-time inserted on every direction reversal.
// Optional build macro MOTORDC_BRAKE_EN: drive both legs high (active brake)
// during the dead-time instead of coasting with both legs low.
module motordc_pwm_dir_drv #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned DEADTIME = 100
) (
    input logic                   ACLK,
    input logic                   ARESET,
    motordc_pwm_dir_drv_if.slave  bus
);

    localparam int unsigned DT_W = $clog2(DEADTIME + 1);

`ifdef MOTORDC_BRAKE_EN
    localparam logic DEAD_LVL = 1'b1;
`else
    localparam logic DEAD_LVL = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DEAD = 2'b10
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DT_W-1:0]   dt_cnt_q;
    logic              dir_act_q;
    logic [CNT_W-1:0]  duty_s_q;
    logic [CNT_W-1:0]  period_s_q;
    logic              in1_q;
    logic              in2_q;
    logic              tick_q;

    logic [CNT_W-1:0]  cnt_inc_c;
    logic              wrap_c;
    logic              pwm_next_c;
    logic              start_on_c;
    logic              dt_done_c;

    // Counter lookahead and the first-cycle PWM level for a fresh period.
    always_comb begin
        cnt_inc_c  = cnt_q + CNT_W'(1);
        wrap_c     = (cnt_q == period_s_q);
        pwm_next_c = (cnt_inc_c < duty_s_q);
        start_on_c = (bus.duty != '0);
        dt_done_c  = (dt_cnt_q == DT_W'(DEADTIME - 1));
    end

    // Driver FSM; every output is registered and aligned with the counter it describes.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            dt_cnt_q   <= '0;
            dir_act_q  <= 1'b0;
            duty_s_q   <= '0;
            period_s_q <= '0;
            in1_q      <= 1'b0;
            in2_q      <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_q  <= '0;
                    in1_q  <= 1'b0;
                    in2_q  <= 1'b0;
                    tick_q <= 1'b0;
                    if (bus.en) begin
                        state_q    <= ST_RUN;
                        dir_act_q  <= bus.dir;
                        duty_s_q   <= bus.duty;
                        period_s_q <= bus.period;
                        in1_q      <= start_on_c & ~bus.dir;
                        in2_q      <= start_on_c & bus.dir;
                        tick_q     <= (bus.period == '0);
                    end
                end

                ST_RUN: begin
                    if (!bus.en) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        in1_q   <= 1'b0;
                        in2_q   <= 1'b0;
                        tick_q  <= 1'b0;
                    end else if (bus.dir != dir_act_q) begin
                        state_q  <= ST_DEAD;
                        dt_cnt_q <= '0;
                        cnt_q    <= '0;
                        in1_q    <= DEAD_LVL;
                        in2_q    <= DEAD_LVL;
                        tick_q   <= 1'b0;
                    end else if (wrap_c) begin
                        // New period: settings captured here stay fixed until the next wrap.
                        cnt_q      <= '0;
                        duty_s_q   <= bus.duty;
                        period_s_q <= bus.period;
                        in1_q      <= start_on_c & ~dir_act_q;
                        in2_q      <= start_on_c & dir_act_q;
                        tick_q     <= (bus.period == '0);
                    end else begin
                        cnt_q  <= cnt_inc_c;
                        in1_q  <= pwm_next_c & ~dir_act_q;
                        in2_q  <= pwm_next_c & dir_act_q;
                        tick_q <= (cnt_inc_c == period_s_q);
                    end
                end

                ST_DEAD: begin
                    if (!bus.en) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        in1_q   <= 1'b0;
                        in2_q   <= 1'b0;
                        tick_q  <= 1'b0;
                    end else if (dt_done_c) begin
                        // Direction is re-sampled here; a bounce back resumes the old one.
                        state_q    <= ST_RUN;
                        dir_act_q  <= bus.dir;
                        duty_s_q   <= bus.duty;
                        period_s_q <= bus.period;
                        cnt_q      <= '0;
                        in1_q      <= start_on_c & ~bus.dir;
                        in2_q      <= start_on_c & bus.dir;
                        tick_q     <= (bus.period == '0);
                    end else begin
                        dt_cnt_q <= dt_cnt_q + DT_W'(1);
                        in1_q    <= DEAD_LVL;
                        in2_q    <= DEAD_LVL;
                        tick_q   <= 1'b0;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    in1_q   <= 1'b0;
                    in2_q   <= 1'b0;
                    tick_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in1         = in1_q;
    assign bus.in2         = in2_q;
    assign bus.dir_act     = dir_act_q;
    assign bus.state_o     = state_q;
    assign bus.period_tick = tick_q;

endmodule

// File: tb/tb_motordc_pwm_dir_drv.sv
// Bench for motordc_pwm_dir_drv (DEADTIME = 4): reference model compared every
// cycle, plus directed windows with hand-computed pulse counts.
module tb_motordc_pwm_dir_drv;

    localparam int CNT_W = 16;
    localparam int DT    = 4;

`ifdef MOTORDC_BRAKE_EN
    localparam bit BRK = 1'b1;
`else
    localparam bit BRK = 1'b0;
`endif

    logic ACLK;
    logic ARESET;

    motordc_pwm_dir_drv_if #(.CNT_W(CNT_W)) bus ();

    motordc_pwm_dir_drv #(.CNT_W(CNT_W), .DEADTIME(DT)) dut (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .bus    (bus)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    // Reference model: mode 0 idle, 1 driving, 2 dead-time countdown.
    int m_mode, m_pos, m_dead_left, m_duty, m_per;
    bit m_dir;

    task automatic m_start();
        m_mode = 1;
        m_pos  = 0;
        m_dir  = bus.dir;
        m_duty = int'(bus.duty);
        m_per  = int'(bus.period);
    endtask

    always @(posedge ACLK) begin
        if (ARESET) begin
            m_mode = 0; m_pos = 0; m_dead_left = 0;
            m_duty = 0; m_per = 0; m_dir = 1'b0;
        end else begin
            case (m_mode)
                0: if (bus.en) m_start();
                1: begin
                    if (!bus.en) m_mode = 0;
                    else if (bus.dir != m_dir) begin
                        m_mode = 2;
                        m_dead_left = DT;
                    end else if (m_pos == m_per) begin
                        m_pos  = 0;
                        m_duty = int'(bus.duty);
                        m_per  = int'(bus.period);
                    end else m_pos = m_pos + 1;
                end
                default: begin
                    if (!bus.en) m_mode = 0;
                    else begin
                        m_dead_left = m_dead_left - 1;
                        if (m_dead_left == 0) m_start();
                    end
                end
            endcase
        end
    end

    int n_cmp, n_bad;
    int tot_in1, tot_in2, tot_tick, tot_dead, tot_run;
    int s_in1, s_in2, s_tick, s_dead, s_run;

    task automatic cycle_checker();
        logic [5:0] got, exp;
        bit e_on;
        forever begin
            @(posedge ACLK);
            #1;
            e_on = (m_mode == 1) && (m_pos < m_duty);
            exp = {(e_on && !m_dir) || (m_mode == 2 && BRK),
                   (e_on && m_dir)  || (m_mode == 2 && BRK),
                   m_dir, 2'(m_mode), (m_mode == 1) && (m_pos == m_per)};
            got = {bus.in1, bus.in2, bus.dir_act, bus.state_o, bus.period_tick};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL cycle t=%0t {in1,in2,dir_act,state,tick} got=%b need=%b", $time, got, exp);
            end
`ifndef MOTORDC_BRAKE_EN
            n_cmp++;
            if (bus.in1 & bus.in2) begin
                n_bad++;
                $display("FAIL shoot_through t=%0t in1=%b in2=%b need not both 1", $time, bus.in1, bus.in2);
            end
`endif
            tot_in1  += int'(bus.in1);
            tot_in2  += int'(bus.in2);
            tot_tick += int'(bus.period_tick);
            tot_run  += int'(bus.state_o == 2'b01);
            tot_dead += int'(bus.state_o == 2'b10 && bus.in1 == BRK && bus.in2 == BRK);
        end
    endtask

    task automatic check_lit(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d need=%0d", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge ACLK);
    endtask

    task automatic snap();
        s_in1 = tot_in1; s_in2 = tot_in2; s_tick = tot_tick;
        s_dead = tot_dead; s_run = tot_run;
    endtask

    // Returns at the falling edge inside a wrap cycle, or flags a timeout.
    task automatic wait_tick();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge ACLK);
            if (bus.period_tick) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL wait_tick got=no_tick need=tick within 50 cycles");
        end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        tot_in1 = 0; tot_in2 = 0; tot_tick = 0; tot_dead = 0; tot_run = 0;
        ARESET = 1'b1;
        bus.en = 1'b0; bus.dir = 1'b0; bus.duty = '0; bus.period = '0;
        fork
            cycle_checker();
        join_none
        step(3);
        check_lit("reset_state", int'(bus.state_o), 0);
        check_lit("reset_in1", int'(bus.in1), 0);
        check_lit("reset_in2", int'(bus.in2), 0);

        // Forward 3/10.
        ARESET = 1'b0;
        bus.period = 16'd9; bus.duty = 16'd3; bus.en = 1'b1;
        step(1);
        snap(); step(30);
        check_lit("fwd_in1_highs", tot_in1 - s_in1, 9);
        check_lit("fwd_in2_highs", tot_in2 - s_in2, 0);
        check_lit("fwd_ticks", tot_tick - s_tick, 3);
        check_lit("fwd_state", int'(bus.state_o), 1);

        // Reversal with dead-time, then reverse 5/10.
        bus.duty = 16'd5;
        step(20);
        bus.dir = 1'b1;
        snap(); step(DT);
        check_lit("dead_cycles", tot_dead - s_dead, DT);
        check_lit("dead_no_run", tot_run - s_run, 0);
        snap(); step(10);
        check_lit("rev_in2_highs", tot_in2 - s_in2, 5);
        check_lit("rev_in1_highs", tot_in1 - s_in1, 0);
        check_lit("rev_dir_act", int'(bus.dir_act), 1);

        // Duty extremes.
        bus.dir = 1'b0; bus.duty = 16'd0;
        step(30);
        snap(); step(10);
        check_lit("duty0_in1", tot_in1 - s_in1, 0);
        bus.duty = 16'd12;
        step(12);
        snap(); step(10);
        check_lit("duty_full_in1", tot_in1 - s_in1, 10);

        // Mid-period duty change 3 -> 7 applies only from the next wrap.
        bus.duty = 16'd3;
        step(12);
        wait_tick();
        step(3);
        bus.duty = 16'd7;
        snap(); step(8);
        check_lit("mid_change_old", tot_in1 - s_in1, 1);
        snap(); step(10);
        check_lit("mid_change_new", tot_in1 - s_in1, 7);

        // Disable at cnt=2.
        bus.duty = 16'd5;
        wait_tick();
        step(3);
        bus.en = 1'b0;
        snap(); step(3);
        check_lit("dis_in1", tot_in1 - s_in1, 0);
        check_lit("dis_state", int'(bus.state_o), 0);

        // Disable during dead-time.
        bus.en = 1'b1;
        step(5);
        bus.dir = 1'b1;
        step(2);
        bus.en = 1'b0;
        snap(); step(8);
        check_lit("dead_dis_run", tot_run - s_run, 0);
        check_lit("dead_dis_dead", tot_dead - s_dead, 0);
        check_lit("dead_dis_state", int'(bus.state_o), 0);

        // Reset pulse during dead-time, then straight into reverse.
        bus.dir = 1'b0; bus.en = 1'b1;
        step(5);
        bus.dir = 1'b1;
        step(2);
        ARESET = 1'b1;
        step(1);
        check_lit("rst_dead_state", int'(bus.state_o), 0);
        check_lit("rst_dead_outs", int'({bus.in1, bus.in2}), 0);
        check_lit("rst_dead_dir_act", int'(bus.dir_act), 0);
        ARESET = 1'b0;
        snap(); step(10);
        check_lit("rst_rev_in2", tot_in2 - s_in2, 5);
        check_lit("rst_rev_nodead", tot_dead - s_dead, 0);

        // Random soak; the per-cycle model compare carries the checking.
        for (int i = 0; i < 10000; i++) begin
            bus.en = ($urandom_range(0, 31) != 0);
            if ($urandom_range(0, 15) == 0) bus.dir = ~bus.dir;
            if ($urandom_range(0, 7) == 0) bus.duty = 16'($urandom_range(0, 12));
            if ($urandom_range(0, 63) == 0) bus.period = 16'($urandom_range(0, 9));
            step(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/motordc_pwm_dir_drv.md
Name: motordc_pwm_dir_drv

Overview:
- Downstream power-stage driver for the DC-motor direction IP. It consumes the AXI-lite register values: enable, direction, duty and period.
- Generates the two H-bridge inputs (IN1/IN2) as an edge-aligned PWM with direction steering.
- Enforces a dead-time whenever the direction reverses, so both bridge legs never conduct together.
- Sits between the AXI slave register bank and the FPGA pins.

Parameters:
- CNT_W, 16, width of the duty, period and PWM counter.
- DEADTIME, 100, ACLK cycles both outputs are held inactive on a direction reversal; must be >= 1.
- DT_W, $clog2(DEADTIME+1), width of the dead-time counter (derived, not overridden).

Ports:
- ACLK  in  1  system clock, shared with the AXI register bank.
- ARESET  in  1  synchronous, active-high reset.
- en  in  1  motor enable (register bit).
- dir  in  1  requested direction: 0 = forward (IN1 pulses), 1 = reverse (IN2 pulses).
- duty  in  CNT_W  high cycles per PWM period.
- period  in  CNT_W  PWM period minus 1, in ACLK cycles.
- in1  out  1  H-bridge input 1, registered.
- in2  out  1  H-bridge input 2, registered.
- dir_act  out  1  direction currently applied to the bridge, registered.
- state_o  out  2  FSM state: 00 IDLE, 01 RUN, 10 DEAD.
- period_tick  out  1  one-cycle pulse at each PWM period wrap in RUN.

Behaviour:
- Clock and reset: one clock, ACLK. ARESET is synchronous and active-high.
- Reset values: state IDLE, in1=0, in2=0, dir_act=0, cnt=0, dt_cnt=0, period_tick=0, shadow regs=0. Reset asserted in any state forces these on the next edge.
- Shadow registers duty_s/period_s:
  - Loaded on entry to RUN and at every period wrap.
  - Mid-period changes to duty/period take effect only at the next wrap.
- PWM counter:
  - cnt counts 0..period_s, then wraps to 0, giving a period of period_s+1 cycles.
  - pwm_on = (cnt < duty_s), compared as unsigned.
  - duty_s=0 gives 0% duty; duty_s > period_s gives 100% duty.
  - period_s=0 gives a 1-cycle period.
- IDLE:
  - in1=in2=0 and cnt held at 0.
  - When en=1 is sampled: go to RUN, set dir_act<=dir, load shadows, cnt<=0.
- RUN:
  - in1 = pwm_on & ~dir_act; in2 = pwm_on & dir_act.
  - en=0 takes priority: go to IDLE, and both outputs are 0 from the next edge.
  - Otherwise, if dir != dir_act: go to DEAD, with dt_cnt<=0.
  - period_tick=1 during the cycle in which cnt==period_s (wrap cycle).
- DEAD:
  - in1=in2=0; dt_cnt increments each cycle.
  - en=0 at any point: go to IDLE immediately.
  - When dt_cnt==DEADTIME-1: go to RUN with dir_act<=dir as sampled on that edge, reload shadows, cnt<=0.
  - dir toggling during DEAD does not restart the dead-time. If dir is back at the old value on exit, RUN resumes in the old direction; the dead-time has still been spent.
- Dead-time length: exactly DEADTIME cycles with both outputs 0 between the last active cycle in the old direction and the first possible active cycle in the new one.
- Latency: outputs are registered. An input sampled at edge k is reflected on in1/in2 from edge k+1.
- Invariant: in1 & in2 never both 1 (without the optional feature).
- dir_act changes only on the DEAD→RUN and IDLE→RUN transitions.

Optional Feature:
- Macro: MOTORDC_BRAKE_EN.
- Defined: during DEAD, in1=in2=1 (active brake, low-side short) for the DEADTIME cycles. The in1&in2 invariant is relaxed in DEAD only. IDLE still drives 0,0.
- Undefined: DEAD drives 0,0 (coast), and in1&in2 are never both 1.

Test Plan:
- Duty/period: period=9, duty=3, dir=0, en=1 → in1 high 3 of every 10 cycles; in2=0; period_tick every 10 cycles; state_o=01.
- Dead-time: DEADTIME=4, running forward at duty=5/period=9, toggle dir → in1=in2=0 for exactly 4 cycles. Then in2 pulses 5/10 and dir_act=1.
- Duty extremes: duty=0 → in1 constant 0. duty=12 with period=9 → in1 constant 1. Mid-period duty change 3→7 takes effect only after the next period_tick.
- Disable: en dropped at cnt=2 (forward, duty=5) → in1=0 from the next edge; state_o=00. en dropped during DEAD → IDLE next edge, no RUN entry.
- Reset mid-operation: ARESET pulsed for 1 cycle during DEAD → all outputs 0 and state_o=00. Re-enable with dir=1 → RUN with in2 pulsing and no dead-time.
- Brake feature: with MOTORDC_BRAKE_EN, repeat the dead-time test → in1=in2=1 for 4 cycles. Without the macro, a bench assertion confirms in1&in2 is never 1 over 10k random en/dir/duty cycles.
